// File: rtl/btn_pkg.sv
// Shared definitions for the push-button UI blocks: FSM state type and 100 MHz timing defaults.
package btn_pkg;

  typedef enum logic [1:0] {S_UP, S_DOWN, S_HOLD} btn_state_t;

  localparam int unsigned DEF_DEBOUNCE_CYCLES = 1_000_000;
  localparam int unsigned DEF_REPEAT_DELAY    = 50_000_000;
  localparam int unsigned DEF_REPEAT_PERIOD   = 10_000_000;
  localparam int unsigned DEF_CNT_W           = 26;

endpackage

// File: rtl/debounce_filter.sv
// Two-flop synchronizer plus stable-count debounce; emits the filtered level and registered
// rise/fall strobes coincident with the level change.
module debounce_filter
  import btn_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned CNT_W           = DEF_CNT_W
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic             s1_q, s2_q;
  logic             lvl_q, rise_q, fall_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             flip;

  // The count only survives while s2 keeps disagreeing with the accepted level.
  always_comb begin
    flip  = 1'b0;
    cnt_d = '0;
    if (s2_q != lvl_q) begin
      if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) flip = 1'b1;
      else                                      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      cnt_q  <= '0;
      lvl_q  <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      s1_q   <= din_i;
      s2_q   <= s1_q;
      cnt_q  <= cnt_d;
      lvl_q  <= lvl_q ^ flip;
      rise_q <= flip & ~lvl_q;
      fall_q <= flip & lvl_q;
    end
  end

  assign level_o = lvl_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;

endmodule

// File: rtl/btn_press_gen.sv
// Button front end: debounce, press/release one-shots, long-hold detection and auto-repeat ticks.
module btn_press_gen
  import btn_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int unsigned REPEAT_PERIOD   = DEF_REPEAT_PERIOD,
  parameter int unsigned CNT_W           = DEF_CNT_W
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  input  logic repeat_en,
  output logic level,
  output logic press,
  output logic release_p,
  output logic long_hold,
  output logic repeat_tick
);

  logic db_level, db_rise, db_fall;

  debounce_filter #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_debounce (
    .clk    (clk),
    .rst_n  (rst_n),
    .din_i  (btn_raw),
    .level_o(db_level),
    .rise_o (db_rise),
    .fall_o (db_fall)
  );

  btn_state_t       state_q, state_d;
  logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
  logic             level_q, press_q, release_q, long_q, tick_q;
  logic             long_d, tick_d;

  // Release is tested before the delay/period expiry so it wins a coincident tick.
  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    long_d     = long_q;
    tick_d     = 1'b0;
    unique case (state_q)
      S_UP: begin
        long_d = 1'b0;
        if (db_rise) begin
          state_d    = S_DOWN;
          hold_cnt_d = '0;
        end
      end
      S_DOWN: begin
        if (db_fall) begin
          state_d    = S_UP;
          hold_cnt_d = '0;
          long_d     = 1'b0;
        end else if (hold_cnt_q == CNT_W'(REPEAT_DELAY - 1)) begin
          state_d    = S_HOLD;
          hold_cnt_d = '0;
          long_d     = 1'b1;
          tick_d     = repeat_en;
        end else begin
          hold_cnt_d = hold_cnt_q + CNT_W'(1);
        end
      end
      S_HOLD: begin
        if (db_fall) begin
          state_d    = S_UP;
          hold_cnt_d = '0;
          long_d     = 1'b0;
        end else if (hold_cnt_q == CNT_W'(REPEAT_PERIOD - 1)) begin
          hold_cnt_d = '0;
          tick_d     = repeat_en;
        end else begin
          hold_cnt_d = hold_cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d    = S_UP;
        hold_cnt_d = '0;
        long_d     = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_UP;
      hold_cnt_q <= '0;
      level_q    <= 1'b0;
      press_q    <= 1'b0;
      release_q  <= 1'b0;
      long_q     <= 1'b0;
      tick_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      level_q    <= db_level;
      press_q    <= db_rise;
      release_q  <= db_fall;
      long_q     <= long_d;
      tick_q     <= tick_d;
    end
  end

  assign level       = level_q;
  assign press       = press_q;
  assign release_p   = release_q;
  assign long_hold   = long_q;
  assign repeat_tick = tick_q;

endmodule

// File: tb/tb_btn_press_gen.sv
// Randomized and directed bench for btn_press_gen against a timing-rule reference model.
module tb_btn_press_gen;

  localparam int unsigned DB = 4;
  localparam int unsigned RD = 20;
  localparam int unsigned RP = 8;
  localparam int unsigned CW = 8;

  logic clk = 1'b0;
  logic rst_n, btn_raw, repeat_en;
  logic level, press, release_p, long_hold, repeat_tick;

  always #5 clk = ~clk;

  btn_press_gen #(
    .DEBOUNCE_CYCLES(DB),
    .REPEAT_DELAY   (RD),
    .REPEAT_PERIOD  (RP),
    .CNT_W          (CW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .btn_raw    (btn_raw),
    .repeat_en  (repeat_en),
    .level      (level),
    .press      (press),
    .release_p  (release_p),
    .long_hold  (long_hold),
    .repeat_tick(repeat_tick)
  );

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int          cyc      = 0;
  logic        chk_en   = 1'b0;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference model: level flips once the last DB synchronized samples all disagree with it,
  // outputs appear one edge later; hold outputs follow from elapsed cycles since press.
  logic hist [DB+2];
  logic ilvl, m_level, m_press, m_rel, m_long, m_tick, all_diff;
  int   pe, d;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DB + 2; i++) hist[i] = 1'b0;
      ilvl = 0; m_level = 0; m_press = 0; m_rel = 0; m_long = 0; m_tick = 0;
    end else begin
      cyc++;
      for (int i = DB + 1; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = btn_raw;
      m_press = ilvl && !m_level;
      m_rel   = !ilvl && m_level;
      m_level = ilvl;
      if (m_press) pe = cyc;
      if (m_level && !m_press) begin
        d      = cyc - pe;
        m_long = (d >= int'(RD));
        m_tick = repeat_en && (d >= int'(RD)) && (((d - int'(RD)) % int'(RP)) == 0);
      end else begin
        m_long = 0;
        m_tick = 0;
      end
      all_diff = 1;
      for (int i = 2; i <= DB + 1; i++) if (hist[i] == ilvl) all_diff = 0;
      if (all_diff) ilvl = !ilvl;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check_eq("level",       level,       m_level);
      check_eq("press",       press,       m_press);
      check_eq("release_p",   release_p,   m_rel);
      check_eq("long_hold",   long_hold,   m_long);
      check_eq("repeat_tick", repeat_tick, m_tick);
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drives btn_raw high before the next edge and measures press latency from that edge.
  task automatic press_and_measure(input string tag);
    int c0, lat;
    btn_raw = 1'b1;
    c0  = cyc + 1;
    lat = -1;
    for (int k = 0; k < 20; k++) begin
      step(1);
      if (press) begin
        lat = cyc - c0;
        break;
      end
    end
    check_eq(tag, lat, DB + 2);
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) step(1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int tgt, plen;
    rst_n = 1'b0; btn_raw = 1'b0; repeat_en = 1'b0;
    step(3);
    chk_en = 1'b1;
    check_eq("rst_level", level, 0);
    check_eq("rst_press", press, 0);
    check_eq("rst_long",  long_hold, 0);
    check_eq("rst_tick",  repeat_tick, 0);
    rst_n = 1'b1;
    step(3);

    // Clean press, long hold with repeat enabled, release.
    repeat_en = 1'b1;
    press_and_measure("clean_press_latency");
    step(1);
    check_eq("press_width", press, 0);
    wait_cyc(pe + 40);
    btn_raw = 1'b0;
    step(15);

    // Bounce that must be rejected, then a real press.
    for (int k = 0; k < 2; k++) begin
      btn_raw = 1'b1; step(3);
      btn_raw = 1'b0; step(1);
    end
    step(10);
    check_eq("bounce_level", level, 0);
    press_and_measure("bounce_press_latency");
    step(5);
    btn_raw = 1'b0;
    step(15);

    // repeat_en low through the delay, re-enabled mid-hold.
    repeat_en = 1'b0;
    press_and_measure("noren_press_latency");
    wait_cyc(pe + 29);
    repeat_en = 1'b1;
    wait_cyc(pe + 36);
    check_eq("resume_tick", repeat_tick, 1);
    check_eq("resume_long", long_hold, 1);
    btn_raw = 1'b0;
    step(15);

    // Release lands on a tick edge.
    press_and_measure("coinc_press_latency");
    tgt = pe + int'(RD) + int'(RP);
    wait_cyc(tgt - int'(DB) - 3);
    btn_raw = 1'b0;
    wait_cyc(tgt);
    check_eq("coinc_release", release_p, 1);
    check_eq("coinc_tick",    repeat_tick, 0);
    check_eq("coinc_long",    long_hold, 0);
    step(15);

    // Asynchronous reset mid-hold, button held through release.
    press_and_measure("prereset_press_latency");
    step(25);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("async_level", level, 0);
    check_eq("async_long",  long_hold, 0);
    check_eq("async_tick",  repeat_tick, 0);
    check_eq("async_press", press, 0);
    check_eq("async_rel",   release_p, 0);
    step(2);
    rst_n = 1'b1;
    press_and_measure("post_reset_press_latency");
    step(10);
    btn_raw = 1'b0;
    step(15);

    // Random glitch trains, holds and repeat_en toggling.
    for (int it = 0; it < 40; it++) begin
      repeat_en = 1'($urandom_range(0, 1));
      for (int g = 0; g < int'($urandom_range(1, 6)); g++) begin
        btn_raw = ~btn_raw;
        step(int'($urandom_range(1, DB + 2)));
      end
      plen = int'($urandom_range(0, 70));
      for (int k = 0; k < plen; k++) begin
        if ($urandom_range(0, 9) == 0) repeat_en = ~repeat_en;
        step(1);
      end
    end
    btn_raw = 1'b0;
    step(20);

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
